// File: rtl/m_dm_store_pkg.sv
// Shared store-path definitions: DM access opcodes and the lane-aligned payload of a queued store.
package m_dm_store_pkg;
  typedef enum logic [1:0] {
    dmWord = 2'b00,
    dmByte = 2'b01,
    dmHalf = 2'b10,
    dmNone = 2'b11
  } dmOp_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } laneData_t;

  // Replicates a byte across all four lanes so any byte enable picks the right copy.
  function automatic logic [31:0] replicateByte(input logic [7:0] b);
    return {4{b}};
  endfunction
endpackage

// File: rtl/m_dm_store_align.sv
// Combinational store alignment: places rt data on the word lanes and derives byte enables.
module m_dm_store_align
  import m_dm_store_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [31:0] data,
  input  logic [1:0]  op,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic        bad
);
  always_comb begin
    byteen = 4'b0000;
    wdata  = data;
    bad    = 1'b0;
    case (dmOp_t'(op))
      dmWord: begin
        byteen = 4'b1111;
        bad    = (addrLo != 2'b00);
      end
      dmHalf: begin
        byteen = addrLo[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{data[15:0]}};
        bad    = addrLo[0];
      end
      dmByte: begin
        byteen = 4'b0001 << addrLo;
        wdata  = replicateByte(data[7:0]);
      end
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/m_dm_store_buffer.sv
// M-stage store buffer: aligns sw/sh/sb requests, queues them in a small FIFO and drains them
// to data memory over valid/ready; misaligned requests are dropped and flagged.
module m_dm_store_buffer
  import m_dm_store_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_addr,
  input  logic [31:0]              req_data,
  input  logic [1:0]               req_op,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_byteen,
  output logic                     misalign,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    alignByteen;
  logic [31:0]   alignWdata;
  logic          alignBad;
  logic          accept;
  logic          push;
  logic          pop;
  logic [PW-1:0] rdPtrReg;
  logic [PW-1:0] wrPtrReg;
  logic [CW-1:0] countReg;
  logic          misalignReg;

  logic [AW-3:0] addrMem [DEPTH];
  laneData_t     laneMem [DEPTH];

  m_dm_store_align uAlign (
    .addrLo (req_addr[1:0]),
    .data   (req_data),
    .op     (req_op),
    .byteen (alignByteen),
    .wdata  (alignWdata),
    .bad    (alignBad)
  );

  assign req_ready = (countReg != CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = accept && !alignBad;
  assign pop       = mem_valid && mem_ready;

  assign mem_valid  = (countReg != '0);
  assign mem_addr   = {addrMem[rdPtrReg], 2'b00};
  assign mem_wdata  = laneMem[rdPtrReg].wdata;
  assign mem_byteen = laneMem[rdPtrReg].byteen;
  assign misalign   = misalignReg;
  assign count      = countReg;

  // Entry storage is not reset: reset only empties the queue via the pointers and count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
    always_ff @(posedge clk) begin
      if (push && (wrPtrReg == PW'(gi))) begin
        addrMem[gi] <= req_addr[AW-1:2];
        laneMem[gi] <= '{wdata: alignWdata, byteen: alignByteen};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtrReg    <= '0;
      wrPtrReg    <= '0;
      countReg    <= '0;
      misalignReg <= 1'b0;
    end else begin
      // op 11 is silently dropped; only genuinely misaligned sh/sw raise the exception pulse.
      misalignReg <= accept && alignBad && (dmOp_t'(req_op) != dmNone);
      if (push) wrPtrReg <= wrPtrReg + PW'(1);
      if (pop)  rdPtrReg <= rdPtrReg + PW'(1);
      case ({push, pop})
        2'b10:   countReg <= countReg + CW'(1);
        2'b01:   countReg <= countReg - CW'(1);
        default: countReg <= countReg;
      endcase
    end
  end
endmodule

// File: tb/tb_m_dm_store_buffer.sv
// Scoreboard bench for m_dm_store_buffer: directed scenarios followed by randomized traffic.
module tb_m_dm_store_buffer;
  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        misalign;
  logic [1:0]  count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } exp_t;

  exp_t expQ[$];
  logic expMis = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   readyMode = 0;

  m_dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_op     (req_op),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .misalign   (misalign),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a legal store puts on the bus, computed from the ISA store rules.
  function automatic bit refModel(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] op, output exp_t e);
    int lane;
    lane     = int'(a[1:0]);
    e.addr   = a & 32'hFFFF_FFFC;
    e.wdata  = 32'h0;
    e.byteen = 4'h0;
    case (op)
      2'b00: begin
        if (lane != 0) return 1'b0;
        e.byteen = 4'hF;
        e.wdata  = d;
      end
      2'b10: begin
        if (lane % 2 != 0) return 1'b0;
        e.byteen = (lane == 2) ? 4'hC : 4'h3;
        e.wdata  = (d & 32'hFFFF) * 32'h0001_0001;
      end
      2'b01: begin
        e.byteen = 4'(1 << lane);
        e.wdata  = (d & 32'hFF) * 32'h0101_0101;
      end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // mem_ready driver; changes land 2 time units after the edge so main-thread mode changes are seen.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       mem_ready = 1'b0;
        1:       mem_ready = 1'b1;
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Transaction-level model updated at each clock edge from pre-edge inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        expQ.delete();
        expMis = 1'b0;
      end else begin
        bit   rdy;
        bit   canPop;
        bit   legal;
        logic newMis;
        exp_t e;
        rdy    = expQ.size() < DEPTH;
        canPop = (expQ.size() != 0) && mem_ready;
        legal  = 1'b0;
        newMis = 1'b0;
        if (req_valid && rdy) begin
          legal = refModel(req_addr, req_data, req_op, e);
          if (!legal) newMis = (req_op != 2'b11);
        end
        if (canPop) void'(expQ.pop_front());
        if (legal) expQ.push_back(e);
        expMis = newMis;
      end
    end
  end

  // Monitor: compares every observable output against the scoreboard mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("req_ready", 32'(req_ready), 32'(expQ.size() < DEPTH));
        chk("count", 32'(count), 32'(expQ.size()));
        chk("mem_valid", 32'(mem_valid), 32'(expQ.size() != 0));
        chk("misalign", 32'(misalign), 32'(expMis));
        if (expQ.size() != 0) begin
          chk("mem_addr", mem_addr, expQ[0].addr);
          chk("mem_wdata", mem_wdata, expQ[0].wdata);
          chk("mem_byteen", 32'(mem_byteen), 32'(expQ[0].byteen));
          if (mem_valid && mem_ready)
            $display("store addr=%h wdata=%h byteen=%b t=%0t", mem_addr, mem_wdata, mem_byteen, $time);
        end
      end
    end
  end

  task automatic sendReq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    int waitCyc;
    bit acc;
    waitCyc   = 0;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_op    = op;
    do begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      waitCyc++;
    end while (!acc && waitCyc < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted addr=%h", a);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_op    = 2'b11;
    #1 reset = 1'b1;
    #1;
    chk("reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_misalign", 32'(misalign), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Word store with an always-ready memory
    readyMode = 1;
    sendReq(32'h10, 32'h1234_5678, 2'b00);
    repeat (3) @(posedge clk);
    #1;

    // Byte then half, drained in order
    sendReq(32'h23, 32'h0000_00AB, 2'b01);
    sendReq(32'h22, 32'h0000_BEEF, 2'b10);
    repeat (3) @(posedge clk);
    #1;

    // Misaligned half and word, plus a no-op
    sendReq(32'h21, 32'h1111_2222, 2'b10);
    sendReq(32'h22, 32'h3333_4444, 2'b00);
    sendReq(32'h40, 32'h5555_6666, 2'b11);
    repeat (2) @(posedge clk);
    #1;

    // Fill with memory stalled, then drain and accept the held third store
    readyMode = 0;
    fork
      begin
        sendReq(32'h100, 32'hA000_0001, 2'b00);
        sendReq(32'h104, 32'hA000_0002, 2'b00);
        sendReq(32'h108, 32'hA000_0003, 2'b00);
      end
      begin
        repeat (6) @(posedge clk);
        #1 readyMode = 1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Push and pop in the same cycle with one entry held
    readyMode = 0;
    sendReq(32'h200, 32'hC0DE_0001, 2'b00);
    readyMode = 1;
    sendReq(32'h205, 32'h0000_0077, 2'b01);
    sendReq(32'h20E, 32'h0000_9988, 2'b10);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with a full buffer
    readyMode = 0;
    sendReq(32'h300, 32'hDEAD_0001, 2'b00);
    sendReq(32'h304, 32'hDEAD_0002, 2'b00);
    #3;
    reset = 1'b1;
    expQ.delete();
    expMis = 1'b0;
    #1;
    chk("async_reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("async_reset_count", 32'(count), 32'h0);
    chk("async_reset_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    readyMode = 1;
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic with a randomly stalling memory
    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        sendReq($urandom, $urandom, 2'($urandom_range(0, 3)));
      end
    end

    readyMode = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
